axi_w_router: RTL

AXI_W_ROUTER -- requirements
Module: axi_w_router

---
 rtl/axi_w_router.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/axi_w_router.sv
// AXI W-channel router: a FIFO of AW targets steers master W beats to one slave.
// Optional AXI_W_REGSLICE_EN adds a per-slave 2-entry skid slice on the slave side.
`ifndef AXI_DATA_BITS
`define AXI_DATA_BITS 32
`endif

module axi_w_router #(
    parameter  int NUM_S       = 6,
    parameter  int ROUTE_DEPTH = 4,
    parameter  int DATA_W      = `AXI_DATA_BITS,
    localparam int STRB_W      = DATA_W / 8,
    localparam int PW          = $clog2(ROUTE_DEPTH),
    localparam int CW          = PW + 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    aw_push_i,
    input  logic [NUM_S-1:0]        aw_sel_i,
    output logic                    aw_ready_o,
    input  logic [DATA_W-1:0]       wdata_m_i,
    input  logic [STRB_W-1:0]       wstrb_m_i,
    input  logic                    wlast_m_i,
    input  logic                    wvalid_m_i,
    output logic                    wready_m_o,
    output logic [NUM_S*DATA_W-1:0] wdata_s_o,
    output logic [NUM_S*STRB_W-1:0] wstrb_s_o,
    output logic [NUM_S-1:0]        wlast_s_o,
    output logic [NUM_S-1:0]        wvalid_s_o,
    input  logic [NUM_S-1:0]        wready_s_i,
    output logic [7:0]              beat_cnt_o,
    output logic [CW-1:0]           route_cnt_o
);

    localparam logic [NUM_S-1:0] DEF_SEL = {1'b1, {(NUM_S-1){1'b0}}};

    logic [NUM_S-1:0] route_q [ROUTE_DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [7:0]       beat_q, beat_d;
    logic             sel_onehot;
    logic             push, pop, accept, empty;
    logic [NUM_S-1:0] sel_norm, head;

    // Anything that is not exactly one-hot falls back to the default slave
    assign sel_onehot = (aw_sel_i != '0) &&
                        ((aw_sel_i & (aw_sel_i - NUM_S'(1))) == '0);
    assign sel_norm   = sel_onehot ? aw_sel_i : DEF_SEL;

    assign aw_ready_o  = cnt_q < CW'(ROUTE_DEPTH);
    assign empty       = (cnt_q == '0);
    assign head        = empty ? '0 : route_q[rd_ptr_q];
    assign push        = aw_push_i & aw_ready_o;
    assign accept      = wvalid_m_i & wready_m_o;
    assign pop         = accept & wlast_m_i;
    assign route_cnt_o = cnt_q;
    assign beat_cnt_o  = beat_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        beat_d   = beat_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        unique case ({push, pop})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
        if (accept) begin
            beat_d = wlast_m_i ? 8'd0 : beat_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            beat_q   <= '0;
            for (int i = 0; i < ROUTE_DEPTH; i++) begin
                route_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            beat_q   <= beat_d;
            if (push) begin
                route_q[wr_ptr_q] <= sel_norm;
            end
        end
    end

`ifdef AXI_W_REGSLICE_EN
    logic [NUM_S-1:0] sk_space;

    // Master sees slice space, so the head slave's stall reaches it a beat late
    assign wready_m_o = |(head & sk_space);

    for (genvar i = 0; i < NUM_S; i++) begin : g_skid
        logic [DATA_W-1:0] data_q [2];
        logic [STRB_W-1:0] strb_q [2];
        logic [1:0]        last_q;
        logic              wp_q, rp_q;
        logic [1:0]        n_q, n_d;
        logic              in_v, out_v;

        assign sk_space[i] = (n_q != 2'd2);
        assign in_v        = head[i] & wvalid_m_i & sk_space[i];
        assign out_v       = wvalid_s_o[i] & wready_s_i[i];
        assign n_d         = n_q + {1'b0, in_v} - {1'b0, out_v};

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                n_q       <= '0;
                wp_q      <= 1'b0;
                rp_q      <= 1'b0;
                last_q    <= '0;
                data_q[0] <= '0;
                data_q[1] <= '0;
                strb_q[0] <= '0;
                strb_q[1] <= '0;
            end else begin
                n_q <= n_d;
                if (in_v) begin
                    data_q[wp_q] <= wdata_m_i;
                    strb_q[wp_q] <= wstrb_m_i;
                    last_q[wp_q] <= wlast_m_i;
                    wp_q         <= ~wp_q;
                end
                if (out_v) begin
                    rp_q <= ~rp_q;
                end
            end
        end

        assign wvalid_s_o[i] = (n_q != 2'd0);
        assign wlast_s_o[i]  = last_q[rp_q];
        assign wdata_s_o[i*DATA_W +: DATA_W] = data_q[rp_q];
        assign wstrb_s_o[i*STRB_W +: STRB_W] =
            wvalid_s_o[i] ? strb_q[rp_q] : '1;
    end
`else
    assign wready_m_o = |(head & wready_s_i);

    for (genvar i = 0; i < NUM_S; i++) begin : g_comb
        assign wvalid_s_o[i] = head[i] & wvalid_m_i;
        assign wlast_s_o[i]  = wlast_m_i;
        assign wdata_s_o[i*DATA_W +: DATA_W] = wdata_m_i;
        assign wstrb_s_o[i*STRB_W +: STRB_W] =
            head[i] ? wstrb_m_i : '1;
    end
`endif

endmodule
